// File: rtl/enc16_pkg.sv
// Shared constants, types and helpers for the 16-to-4 sequential encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro used by importers: ENC16_RR_EN (round-robin select).
package enc16_pkg;

    localparam int ENC_N = 16;
    localparam int ENC_W = 4;

    typedef logic [ENC_W-1:0] enc_code_t;
    typedef logic [ENC_N-1:0] enc_vec_t;

    // One-hot mask for a request index, used to retire the granted bit.
    function automatic enc_vec_t onehot16(input enc_code_t code);
        return enc_vec_t'(1) << code;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Find-first-set over 16 bits, scanning upward from a start offset (mod 16).
// Latency: purely combinational, 0 cycles.
// Backpressure: none, no handshake.
// Ports: vec (request set), start (scan origin, tie to 0 for fixed priority),
//        idx (first set index at or after start), any (vec non-zero).
module prio_enc16
    import enc16_pkg::*;
(
    input  logic [ENC_N-1:0] vec,
    input  logic [ENC_W-1:0] start,
    output logic [ENC_W-1:0] idx,
    output logic             any
);

    logic [2*ENC_N-1:0] dbl;
    logic [ENC_N-1:0]   rot;
    enc_code_t          off;

    always_comb begin
        // Rotate so that bit 'start' sits at position 0; lowest set bit of
        // the rotated vector is then the first hit of the circular scan.
        dbl = {vec, vec} >> start;
        rot = dbl[ENC_N-1:0];
        off = '0;
        for (int i = ENC_N - 1; i >= 0; i--) begin
            if (rot[i]) off = ENC_W'(i);
        end
        idx = off + start;   // 4-bit add wraps modulo 16
        any = |vec;
    end

endmodule

// File: rtl/enc16_queue.sv
// Captures 16 request strobes into a pending set and emits them one at a time as 4-bit codes.
// Latency: req sampled at edge t is pending at t+1 and can be presented with code_valid at t+2.
// Backpressure: code_ready low holds code/code_valid; pending keeps accumulating, duplicates set sticky ovf.
// Ports: clk, rst (sync active-high), req[15:0] in; code[3:0], code_valid out; code_ready in;
//        pending[15:0], ovf out (debug/verification visibility).
// Build option: define ENC16_RR_EN for round-robin selection, otherwise lowest index wins.
module enc16_queue
    import enc16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ENC_N-1:0] req,
    output logic [ENC_W-1:0] code,
    output logic             code_valid,
    input  logic             code_ready,
    output logic [ENC_N-1:0] pending,
    output logic             ovf
);

    enc_vec_t  pending_q, pending_d;
    enc_code_t code_q,    code_d;
    logic      valid_q,   valid_d;
    logic      ovf_q,     ovf_d;

    enc_code_t scan_start;
    enc_code_t sel;
    logic      any_pending;
    logic      fire;
    logic      free;
    logic      grant;
    enc_vec_t  gnt_mask;

`ifdef ENC16_RR_EN
    enc_code_t rr_q, rr_d;
    assign scan_start = rr_q;
`else
    assign scan_start = '0;
`endif

    prio_enc16 u_prio (
        .vec   (pending_q),
        .start (scan_start),
        .idx   (sel),
        .any   (any_pending)
    );

    always_comb begin
        fire     = valid_q & code_ready;
        free     = ~valid_q | fire;
        grant    = free & any_pending;
        gnt_mask = grant ? onehot16(sel) : '0;

        // A strobe on the bit being granted is a fresh request, so it is
        // re-posted without counting as a merge.
        pending_d = (pending_q & ~gnt_mask) | req;
        ovf_d     = ovf_q | (|(req & pending_q & ~gnt_mask));

        code_d  = code_q;
        valid_d = valid_q & ~fire;
        if (grant) begin
            code_d  = sel;
            valid_d = 1'b1;
        end
    end

`ifdef ENC16_RR_EN
    always_comb begin
        rr_d = rr_q;
        if (grant) rr_d = sel + 4'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef ENC16_RR_EN
    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
`endif

    assign code       = code_q;
    assign code_valid = valid_q;
    assign pending    = pending_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_enc16_queue.sv
// Self-checking bench for enc16_queue: directed scenarios plus randomized traffic against a set-based model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
// Honours ENC16_RR_EN to choose the expected selection order.
module tb_enc16_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic        code_ready = 1'b0;
    logic [3:0]  code;
    logic        code_valid;
    logic [15:0] pending;
    logic        ovf;

    int n_vec = 0;
    int n_err = 0;

    enc16_queue dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending    (pending),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: pending requests as a set of indices.
    bit m_set [16];
    int m_code = 0;
    bit m_vld  = 0;
    int m_rr   = 0;
    bit m_ovf  = 0;

    function automatic logic [15:0] m_pending();
        logic [15:0] v = '0;
        for (int k = 0; k < 16; k++) if (m_set[k]) v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        bit fire, free;
        int g;
        if (rst) begin
            foreach (m_set[k]) m_set[k] = 0;
            m_code = 0; m_vld = 0; m_rr = 0; m_ovf = 0;
            return;
        end
        fire = m_vld && code_ready;
        free = !m_vld || fire;
        g = -1;
        if (free) begin
            for (int off = 0; off < 16; off++) begin
                if (g < 0 && m_set[(m_rr + off) % 16]) g = (m_rr + off) % 16;
            end
        end
        if (g >= 0) begin
            m_set[g] = 0;
            m_code = g;
            m_vld = 1;
`ifdef ENC16_RR_EN
            m_rr = (g + 1) % 16;
`endif
        end else if (fire) begin
            m_vld = 0;
        end
        for (int k = 0; k < 16; k++) begin
            if (req[k]) begin
                if (m_set[k]) m_ovf = 1;
                m_set[k] = 1;
            end
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; code_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 16'hFFFF;   // must be ignored in the reset cycle
        rst = 1'b1;
        tick();
        rst = 1'b0; req = '0;
        n_vec++; if (code !== 4'd0)        begin n_err++; $display("FAIL reset_code got=%0d exp=0", code); end
        n_vec++; if (code_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
        n_vec++; if (pending !== 16'h0000) begin n_err++; $display("FAIL reset_pending got=%h exp=0000", pending); end
        n_vec++; if (ovf !== 1'b0)         begin n_err++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_single();
        do_reset();
        code_ready = 1'b1;
        req = 16'h0020;
        tick();
        req = '0;
        n_vec++; if (code_valid !== 1'b0 || pending !== 16'h0020) begin n_err++; $display("FAIL single_t1 valid=%b pending=%h exp valid=0 pending=0020", code_valid, pending); end
        tick();
        n_vec++; if (code_valid !== 1'b1 || code !== 4'd5) begin n_err++; $display("FAIL single_t2 valid=%b code=%0d exp valid=1 code=5", code_valid, code); end
        tick();
        n_vec++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL single_once valid=%b exp=0", code_valid); end
        n_vec++; if (pending !== 16'h0000 || ovf !== 1'b0) begin n_err++; $display("FAIL single_after pending=%h ovf=%b exp 0000/0", pending, ovf); end
    endtask

    task automatic test_burst();
        int exp_codes [4] = '{0, 5, 10, 15};
        do_reset();
        code_ready = 1'b1;
        req = 16'h8421;
        tick();
        req = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (code_valid !== 1'b1 || code !== 4'(exp_codes[i])) begin
                n_err++; $display("FAIL burst_%0d valid=%b code=%0d exp valid=1 code=%0d", i, code_valid, code, exp_codes[i]);
            end
        end
        tick();
        n_vec++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL burst_end valid=%b exp=0", code_valid); end
    endtask

    task automatic test_wrap();
`ifdef ENC16_RR_EN
        int first = 10, second = 0;
`else
        int first = 0, second = 10;
`endif
        do_reset();
        code_ready = 1'b1;
        req = 16'h0200;
        tick();
        req = '0;
        tick();
        n_vec++; if (code_valid !== 1'b1 || code !== 4'd9) begin n_err++; $display("FAIL wrap_9 valid=%b code=%0d exp 1/9", code_valid, code); end
        req = 16'h0401;
        tick();
        req = '0;
        tick();
        n_vec++; if (code_valid !== 1'b1 || code !== 4'(first)) begin n_err++; $display("FAIL wrap_first valid=%b code=%0d exp 1/%0d", code_valid, code, first); end
        tick();
        n_vec++; if (code_valid !== 1'b1 || code !== 4'(second)) begin n_err++; $display("FAIL wrap_second valid=%b code=%0d exp 1/%0d", code_valid, code, second); end
    endtask

    task automatic test_backpressure();
        do_reset();
        code_ready = 1'b0;
        req = 16'h0008; tick();
        req = '0;       tick();
        req = 16'h0010; tick();
        req = '0;       tick();
        req = 16'h0010; tick();
        req = '0;       tick();
        n_vec++; if (code_valid !== 1'b1 || code !== 4'd3) begin n_err++; $display("FAIL bp_hold valid=%b code=%0d exp 1/3", code_valid, code); end
        n_vec++; if (pending !== 16'h0010) begin n_err++; $display("FAIL bp_pending got=%h exp=0010", pending); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL bp_ovf got=%b exp=1", ovf); end
        code_ready = 1'b1;
        tick();
        n_vec++; if (code_valid !== 1'b1 || code !== 4'd4) begin n_err++; $display("FAIL bp_next valid=%b code=%0d exp 1/4", code_valid, code); end
        tick();
        n_vec++; if (code_valid !== 1'b0 || pending !== 16'h0000) begin n_err++; $display("FAIL bp_drain valid=%b pending=%h exp 0/0000", code_valid, pending); end
    endtask

    task automatic test_repost();
        do_reset();
        code_ready = 1'b1;
        req = 16'h0004; tick();
        req = 16'h0004; tick();   // bit 2 granted on this edge and struck again
        req = '0;
        n_vec++; if (code_valid !== 1'b1 || code !== 4'd2 || pending[2] !== 1'b1) begin n_err++; $display("FAIL repost_t1 valid=%b code=%0d p2=%b exp 1/2/1", code_valid, code, pending[2]); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL repost_ovf got=%b exp=0", ovf); end
        tick();
        n_vec++; if (code_valid !== 1'b1 || code !== 4'd2 || pending !== 16'h0000) begin n_err++; $display("FAIL repost_t2 valid=%b code=%0d pending=%h exp 1/2/0000", code_valid, code, pending); end
        tick();
        n_vec++; if (code_valid !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL repost_end valid=%b ovf=%b exp 0/0", code_valid, ovf); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        code_ready = 1'b0;
        req = 16'hFFFF; tick();
        tick();
        n_vec++; if (code_valid !== 1'b1 || pending !== 16'hFFFF) begin n_err++; $display("FAIL rmid_pre valid=%b pending=%h exp 1/ffff", code_valid, pending); end
        rst = 1'b1; code_ready = 1'b1;
        tick();
        rst = 1'b0; req = '0;
        n_vec++; if (code !== 4'd0 || code_valid !== 1'b0 || pending !== 16'h0000 || ovf !== 1'b0) begin
            n_err++; $display("FAIL rmid_reset code=%0d valid=%b pending=%h ovf=%b exp 0/0/0000/0", code, code_valid, pending, ovf);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (code_valid !== 1'b0 || pending !== 16'h0000) begin n_err++; $display("FAIL rmid_idle_%0d valid=%b pending=%h exp 0/0000", i, code_valid, pending); end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            req = '0;
            if ($urandom_range(0, 7) == 0) req = 16'($urandom);
            else for (int k = 0; k < 16; k++) if ($urandom_range(0, 15) == 0) req[k] = 1'b1;
            code_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
            n_vec++;
            if (code_valid !== m_vld || pending !== m_pending() || ovf !== m_ovf ||
                (m_vld && code !== 4'(m_code))) begin
                n_err++;
                if (bad < 10) $display("FAIL rand_cyc%0d valid=%b code=%0d pending=%h ovf=%b exp valid=%b code=%0d pending=%h ovf=%b",
                                       c, code_valid, code, pending, ovf, m_vld, m_code, m_pending(), m_ovf);
                bad++;
            end
        end
        rst = 1'b0; req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_backpressure();
        test_repost();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
